// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default controller address and data widths
//   IDLE / BUSY / RESP      : arbiter state encoding
//   idx_w()                 : width of a port index for a given port count
package sdram_arb_pkg;

   localparam int ADDR_W_DEF = 21;
   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_BUSY = BUSY,
      ST_RESP = RESP
   } arb_state_e;

   // A single-port build still needs a one-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_chk.sv
// Protocol checker for the controller side of the SDRAM port arbiter.
//   clk, reset  : arbiter clock and synchronous reset
//   busy_i      : arbiter has an access outstanding at the controller
//   mem_valid_i : valid as seen by the controller
//   mem_ready_i : completion pulse from the controller
module sdram_port_arbiter_chk (
   input logic clk,
   input logic reset,
   input logic busy_i,
   input logic mem_valid_i,
   input logic mem_ready_i
);

   // A completion with nothing outstanding is dropped by the arbiter; report it,
   // and make sure valid never overlaps a completion.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (busy_i || !mem_ready_i)
            else $warning("sdram_port_arbiter: mem_ready with no access outstanding was ignored (protocol error)");
         assert (!(mem_valid_i && mem_ready_i))
            else $error("sdram_port_arbiter: mem_valid high in a mem_ready cycle");
      end
   end

endmodule

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req_i     : request vector, one bit per port
//   last_i    : index of the previously granted port
//   grant_o   : first requesting port after last_i (wrapping)
//   any_req_o : at least one port is requesting
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = idx_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [IDX_W-1:0]     last_i,
   output logic [IDX_W-1:0]     grant_o,
   output logic                 any_req_o
);

   // Scan from last_i+1 around to last_i itself; the first requester found wins,
   // so the previous winner is considered only when nobody else is asking.
   always_comb begin
      logic [IDX_W-1:0] idx_s;
      logic             hit_s;
      idx_s     = {IDX_W{1'b0}};
      hit_s     = 1'b0;
      grant_o   = last_i;
      any_req_o = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx_s     = IDX_W'((int'(last_i) + k) % NUM_PORTS);
         hit_s     = !any_req_o && req_i[idx_s];
         grant_o   = hit_s ? idx_s : grant_o;
         any_req_o = any_req_o | hit_s;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between NUM_PORTS requesters.
//   req_*  : per-port requests (packed, port 0 in the LSBs), one-cycle
//            req_ready completion per port, shared req_rdata
//   mem_*  : controller request (held stable for the whole access) and
//            its one-cycle mem_ready completion with mem_rdata
// Grants rotate round-robin; each access costs one capture cycle and one
// response cycle on top of the controller latency.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          req_valid,
   input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
   input  logic [NUM_PORTS*DATA_W/8-1:0] req_wmask,
   output logic [NUM_PORTS-1:0]          req_ready,
   output logic [DATA_W-1:0]             req_rdata,
   output logic                          mem_valid,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic [DATA_W/8-1:0]           mem_wmask,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_ready
);

   localparam int IDX_W  = idx_w(NUM_PORTS);
   localparam int MASK_W = DATA_W / 8;

   arb_state_e           state_q;
   logic [IDX_W-1:0]     grant_q;
   logic [IDX_W-1:0]     last_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [MASK_W-1:0]    wmask_q;
   logic [NUM_PORTS-1:0] ready_q;
   logic [DATA_W-1:0]    rdata_q;

   logic [IDX_W-1:0]     pick_s;
   logic                 any_s;
   logic                 busy_s;

   logic [ADDR_W-1:0]    addr_a  [NUM_PORTS];
   logic [DATA_W-1:0]    wdata_a [NUM_PORTS];
   logic [MASK_W-1:0]    wmask_a [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign addr_a[p]  = req_addr[p*ADDR_W +: ADDR_W];
      assign wdata_a[p] = req_wdata[p*DATA_W +: DATA_W];
      assign wmask_a[p] = req_wmask[p*MASK_W +: MASK_W];
   end

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr_pick (
      .req_i     (req_valid),
      .last_i    (last_q),
      .grant_o   (pick_s),
      .any_req_o (any_s)
   );

   assign busy_s = (state_q == ST_BUSY);

   // The controller samples valid in the very cycle it raises ready, so valid
   // is gated off combinationally there to avoid launching a second access.
   assign mem_valid = busy_s & ~mem_ready;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign req_ready = ready_q;
   assign req_rdata = rdata_q;

   sdram_port_arbiter_chk u_chk (
      .clk         (clk),
      .reset       (reset),
      .busy_i      (busy_s),
      .mem_valid_i (mem_valid),
      .mem_ready_i (mem_ready)
   );

   // Arbiter FSM with capture registers and registered response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= {IDX_W{1'b0}};
         last_q  <= IDX_W'(NUM_PORTS - 1);
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         wmask_q <= {MASK_W{1'b0}};
         ready_q <= {NUM_PORTS{1'b0}};
         rdata_q <= {DATA_W{1'b0}};
      end else begin
         ready_q <= {NUM_PORTS{1'b0}};
         case (state_q)
            ST_IDLE: begin
               if (any_s) begin
                  grant_q <= pick_s;
                  last_q  <= pick_s;
                  addr_q  <= addr_a[pick_s];
                  wdata_q <= wdata_a[pick_s];
                  wmask_q <= wmask_a[pick_s];
                  state_q <= ST_BUSY;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (mem_ready) begin
                  rdata_q <= mem_rdata;
                  ready_q <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q;
                  state_q <= ST_RESP;
               end else begin
                  state_q <= ST_BUSY;
               end
            end
            // The granted port still holds req_valid here; skipping arbitration
            // in this cycle keeps it from being granted a second time.
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

   localparam int N  = 2;
   localparam int AW = 21;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N*MW-1:0]   req_wmask;
   logic [N-1:0]      req_ready;
   logic [DW-1:0]     req_rdata;
   logic              mem_valid;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [MW-1:0]     mem_wmask;
   logic [DW-1:0]     mem_rdata;
   logic              mem_ready;

   always #5 clk = ~clk;

   sdram_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .req_ready(req_ready), .req_rdata(req_rdata),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Controller model
   int            lat_cfg = 3;
   bit            lat_rand = 1'b0;
   bit            ctl_busy = 1'b0;
   int            ctl_wait = 0;
   int            ctl_accesses = 0;
   bit            stray_req = 1'b0;
   logic [AW-1:0] ctl_addr;
   logic [DW-1:0] ctl_wdata;
   logic [MW-1:0] ctl_wmask;
   logic [DW-1:0] ctl_mem [int];

   // Reference model and scoreboard
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [MW-1:0] m; } acc_t;
   acc_t          acc_q[$];
   int            exp_port_q[$];
   int            order_q[$];
   int            exp_last = N - 1;
   logic [N-1:0]  cap_valid = '0;
   logic [DW-1:0] ref_mem [int];
   logic [AW-1:0] p_addr  [N];
   logic [DW-1:0] p_wdata [N];
   logic [MW-1:0] p_wmask [N];
   int            wait_cnt [N];
   int            ready_pulses = 0;
   int            mv_cyc = -1;
   int            mr_cyc = -1;
   int            rr_cyc = -1;

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return {11'h5A5, a} ^ 32'h0F0F_0F0F;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = o;
      for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   task automatic set_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
      p_addr[p] = a; p_wdata[p] = d; p_wmask[p] = m; wait_cnt[p] = 0;
      req_addr[p*AW +: AW]  = a;
      req_wdata[p*DW +: DW] = d;
      req_wmask[p*MW +: MW] = m;
      req_valid[p] = 1'b1;
   endtask

   // One clock: controller drive just after the rising edge, then sampling at
   // the falling edge. Returns at the falling edge of cycle cyc.
   task automatic tick();
      int p;
      int e;
      acc_t a;
      logic [DW-1:0] exp_rd;
      @(posedge clk);
      cap_valid = req_valid;
      cyc++;
      #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (stray_req) begin
         mem_ready = 1'b1;
         stray_req = 1'b0;
      end else if (ctl_busy) begin
         if (ctl_wait == 0) begin
            mem_rdata = ctl_mem.exists(int'(ctl_addr)) ? ctl_mem[int'(ctl_addr)] : dflt(ctl_addr);
            if (ctl_wmask != 4'h0) ctl_mem[int'(ctl_addr)] = merge(mem_rdata, ctl_wdata, ctl_wmask);
            mem_ready = 1'b1;
            mr_cyc    = cyc;
            ctl_busy  = 1'b0;
         end else begin
            ctl_wait--;
         end
      end
      @(negedge clk);
      if (mem_ready === 1'b1) begin
         n_checks++;
         if (mem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_double_issue cyc=%0d mem_valid=%b required 0", cyc, mem_valid);
         end
      end
      if (!ctl_busy && mem_valid === 1'b1) begin
         ctl_busy = 1'b1;
         ctl_accesses++;
         ctl_addr = mem_addr; ctl_wdata = mem_wdata; ctl_wmask = mem_wmask;
         ctl_wait = lat_rand ? $urandom_range(0, 6) : lat_cfg;
         mv_cyc   = cyc;
         acc_q.push_back('{mem_addr, mem_wdata, mem_wmask});
         e = -1;
         for (int k = 1; k <= N; k++)
            if (e < 0 && cap_valid[(exp_last + k) % N]) e = (exp_last + k) % N;
         n_checks++;
         if (e < 0) begin
            n_err++;
            $display("FAIL spurious_access cyc=%0d requests=%b required nonzero", cyc, cap_valid);
         end else begin
            exp_last = e;
            exp_port_q.push_back(e);
         end
      end else if (ctl_busy) begin
         n_checks++;
         if (mem_valid !== 1'b1 || mem_addr !== ctl_addr || mem_wdata !== ctl_wdata || mem_wmask !== ctl_wmask) begin
            n_err++;
            $display("FAIL busy_stable cyc=%0d got v=%b a=%h d=%h m=%h required v=1 a=%h d=%h m=%h",
                     cyc, mem_valid, mem_addr, mem_wdata, mem_wmask, ctl_addr, ctl_wdata, ctl_wmask);
         end
      end
      if (req_ready !== '0) begin
         ready_pulses++;
         rr_cyc = cyc;
         n_checks++;
         if ($countones(req_ready) != 1 || acc_q.size() == 0 || exp_port_q.size() == 0) begin
            n_err++;
            $display("FAIL resp_unexpected cyc=%0d req_ready=%b outstanding=%0d required one-hot with 1 outstanding",
                     cyc, req_ready, acc_q.size());
         end else begin
            p = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) p = i;
            e = exp_port_q.pop_front();
            a = acc_q.pop_front();
            order_q.push_back(p);
            n_checks++;
            if (p != e) begin
               n_err++;
               $display("FAIL rr_order cyc=%0d port=%0d required %0d", cyc, p, e);
            end
            n_checks++;
            if (a.a !== p_addr[p] || a.d !== p_wdata[p] || a.m !== p_wmask[p]) begin
               n_err++;
               $display("FAIL capture port=%0d got a=%h d=%h m=%h required a=%h d=%h m=%h",
                        p, a.a, a.d, a.m, p_addr[p], p_wdata[p], p_wmask[p]);
            end
            exp_rd = ref_mem.exists(int'(a.a)) ? ref_mem[int'(a.a)] : dflt(a.a);
            if (a.m != 4'h0) ref_mem[int'(a.a)] = merge(exp_rd, a.d, a.m);
            n_checks++;
            if (req_rdata !== exp_rd) begin
               n_err++;
               $display("FAIL rdata port=%0d got %h required %h", p, req_rdata, exp_rd);
            end
            for (int q = 0; q < N; q++) if (q != p && req_valid[q]) wait_cnt[q]++;
            n_checks++;
            if (wait_cnt[p] > N - 1) begin
               n_err++;
               $display("FAIL starvation port=%0d waited %0d required <= %0d", p, wait_cnt[p], N - 1);
            end
            req_valid[p] = 1'b0;
         end
      end
   endtask

   task automatic wait_ready(input int p, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         if (req_ready[p] === 1'b1) ok = 1'b1;
      end
   endtask

   // Called at a falling edge; reset is held for the given number of rising edges.
   task automatic apply_reset(input int cycles);
      reset = 1'b1;
      req_valid = '0; mem_ready = 1'b0; ctl_busy = 1'b0; stray_req = 1'b0;
      acc_q.delete(); exp_port_q.delete();
      exp_last = N - 1;
      repeat (cycles) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset(3);
      n_checks++;
      if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin
         n_err++;
         $display("FAIL reset_ctrl mem_valid=%b req_ready=%b required 0 00", mem_valid, req_ready);
      end
      n_checks++;
      if (mem_addr !== 21'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
         n_err++;
         $display("FAIL reset_mem a=%h d=%h m=%h required zeros", mem_addr, mem_wdata, mem_wmask);
      end
      n_checks++;
      if (req_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_rdata got %h required 0", req_rdata);
      end
   endtask

   task automatic test_single_read();
      int t;
      bit ok;
      ctl_mem[21'h00123] = 32'hDEAD_BEEF;
      ref_mem[21'h00123] = 32'hDEAD_BEEF;
      lat_cfg = 10;
      t = cyc;
      set_req(0, 21'h00123, 32'h0, 4'h0);
      tick();
      n_checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 21'h00123 || mem_wmask !== 4'h0) begin
         n_err++;
         $display("FAIL read_issue cyc=%0d v=%b a=%h m=%h required 1 00123 0", cyc, mem_valid, mem_addr, mem_wmask);
      end
      wait_ready(0, ok);
      n_checks++;
      if (!ok || req_ready !== 2'b01 || req_rdata !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL read_resp ready=%b rdata=%h required 01 deadbeef", req_ready, req_rdata);
      end
      n_checks++;
      if (mv_cyc != t + 1 || rr_cyc != mr_cyc + 1) begin
         n_err++;
         $display("FAIL read_timing valid_at=%0d ready_at=%0d required %0d %0d", mv_cyc, rr_cyc, t + 1, mr_cyc + 1);
      end
   endtask

   task automatic test_write_passthrough();
      bit ok;
      int busy_cycles;
      logic [DW-1:0] exp_word;
      lat_cfg = 5;
      busy_cycles = 0;
      ok = 1'b0;
      set_req(1, 21'h1FFFFF, 32'h1122_3344, 4'b0101);
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         if (mem_valid === 1'b1) begin
            busy_cycles++;
            n_checks++;
            if (mem_addr !== 21'h1FFFFF || mem_wdata !== 32'h1122_3344 || mem_wmask !== 4'b0101) begin
               n_err++;
               $display("FAIL write_pass cyc=%0d a=%h d=%h m=%h required 1fffff 11223344 5",
                        cyc, mem_addr, mem_wdata, mem_wmask);
            end
         end
         if (req_ready[1] === 1'b1) ok = 1'b1;
      end
      exp_word = dflt(21'h1FFFFF);
      exp_word[7:0]   = 8'h44;
      exp_word[23:16] = 8'h22;
      n_checks++;
      if (!ok || busy_cycles != 6 || ctl_mem[21'h1FFFFF] !== exp_word) begin
         n_err++;
         $display("FAIL write_done ok=%0d busy=%0d word=%h required 1 6 %h",
                  ok, busy_cycles, ctl_mem[21'h1FFFFF], exp_word);
      end
   endtask

   task automatic test_contention();
      int issued;
      int pulses0;
      int acc0;
      int exp_order[6] = '{0, 1, 0, 1, 0, 1};
      apply_reset(1);
      lat_cfg = 2;
      order_q.delete();
      pulses0 = ready_pulses;
      acc0 = ctl_accesses;
      set_req(0, 21'h00200, 32'hA000_0000, 4'hF);
      set_req(1, 21'h00300, 32'hB000_0000, 4'h0);
      issued = 2;
      for (int i = 0; i < 400 && (ready_pulses - pulses0) < 6; i++) begin
         tick();
         for (int p = 0; p < N; p++)
            if (!req_valid[p] && issued < 6) begin
               set_req(p, 21'(21'h00200 + 21'(issued)), 32'(issued), (p == 0) ? 4'hF : 4'h0);
               issued++;
            end
      end
      n_checks++;
      if (ready_pulses - pulses0 != 6 || ctl_accesses - acc0 != 6) begin
         n_err++;
         $display("FAIL contention_count pulses=%0d accesses=%0d required 6 6",
                  ready_pulses - pulses0, ctl_accesses - acc0);
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (k >= order_q.size() || order_q[k] != exp_order[k]) begin
            n_err++;
            $display("FAIL contention_order idx=%0d got %0d required %0d",
                     k, (k < order_q.size()) ? order_q[k] : -1, exp_order[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int issued;
      int pulses0;
      int acc0;
      lat_cfg = 0;
      pulses0 = ready_pulses;
      acc0 = ctl_accesses;
      set_req(0, 21'h00010, 32'h0, 4'h0);
      issued = 1;
      for (int i = 0; i < 100 && (ready_pulses - pulses0) < 3; i++) begin
         tick();
         if (!req_valid[0] && issued < 3) begin
            set_req(0, 21'(21'h00010 + 21'(issued)), 32'h0, 4'h0);
            issued++;
         end
      end
      repeat (4) tick();
      n_checks++;
      if (ready_pulses - pulses0 != 3 || ctl_accesses - acc0 != 3) begin
         n_err++;
         $display("FAIL back_to_back pulses=%0d accesses=%0d required 3 3",
                  ready_pulses - pulses0, ctl_accesses - acc0);
      end
   endtask

   task automatic test_reset_mid_access();
      int pulses0;
      int t;
      bit ok;
      lat_cfg = 10;
      set_req(0, 21'h00077, 32'h0, 4'h0);
      repeat (3) tick();
      n_checks++;
      if (mem_valid !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_busy mem_valid=%b required 1", mem_valid);
      end
      apply_reset(1);
      n_checks++;
      if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin
         n_err++;
         $display("FAIL midrst_after mem_valid=%b req_ready=%b required 0 00", mem_valid, req_ready);
      end
      pulses0 = ready_pulses;
      repeat (15) tick();
      n_checks++;
      if (ready_pulses != pulses0 || mem_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_aborted pulses=%0d mem_valid=%b required 0 0", ready_pulses - pulses0, mem_valid);
      end
      t = cyc;
      set_req(0, 21'h00078, 32'h0, 4'h0);
      wait_ready(0, ok);
      n_checks++;
      if (!ok || mv_cyc != t + 1) begin
         n_err++;
         $display("FAIL midrst_next ok=%0d valid_at=%0d required 1 %0d", ok, mv_cyc, t + 1);
      end
   endtask

   task automatic test_stray_ready();
      int pulses0;
      int t;
      bit ok;
      lat_cfg = 3;
      pulses0 = ready_pulses;
      stray_req = 1'b1;
      repeat (4) begin
         tick();
         n_checks++;
         if (req_ready !== 2'b00 || mem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stray_ready cyc=%0d req_ready=%b mem_valid=%b required 00 0", cyc, req_ready, mem_valid);
         end
      end
      t = cyc;
      set_req(1, 21'h00500, 32'h0, 4'h0);
      wait_ready(1, ok);
      n_checks++;
      if (!ok || mv_cyc != t + 1 || ready_pulses - pulses0 != 1) begin
         n_err++;
         $display("FAIL stray_next ok=%0d valid_at=%0d pulses=%0d required 1 %0d 1",
                  ok, mv_cyc, ready_pulses - pulses0, t + 1);
      end
   endtask

   task automatic test_random();
      int issued;
      int pulses0;
      lat_rand = 1'b1;
      issued = 0;
      pulses0 = ready_pulses;
      for (int i = 0; i < 400; i++) begin
         tick();
         for (int p = 0; p < N; p++)
            if (!req_valid[p] && $urandom_range(0, 99) < 30) begin
               set_req(p, 21'(21'h00040 + 21'($urandom_range(0, 7))), $urandom,
                       ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
               issued++;
            end
      end
      for (int i = 0; i < 200 && (req_valid != '0 || ctl_busy); i++) tick();
      repeat (3) tick();
      lat_rand = 1'b0;
      n_checks++;
      if (ready_pulses - pulses0 != issued || req_valid != '0) begin
         n_err++;
         $display("FAIL random_drain done=%0d issued=%0d pending=%b required equal 00",
                  ready_pulses - pulses0, issued, req_valid);
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
      mem_rdata = 32'h0; mem_ready = 1'b0;
      for (int p = 0; p < N; p++) begin
         p_addr[p] = '0; p_wdata[p] = '0; p_wmask[p] = '0; wait_cnt[p] = 0;
      end
      test_reset();
      test_single_read();
      test_write_passthrough();
      test_contention();
      test_back_to_back();
      test_reset_mid_access();
      test_stray_ready();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d required completion before time limit", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single-port SDRAM controller (21-bit word address, 32-bit data, 4-bit write mask, valid/ready) between NUM_PORTS requesters, for example the CPU data port and a DMA/framebuffer reader. It sits directly in front of the controller. Each request is captured and forwarded, and the controller's completion is routed back to the granted requester. Grants rotate round-robin. The block keeps the controller's request stable for the whole access and never lets the controller see a stale valid that would start an unintended second access.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesters, 2..4.
- ADDR_W, 21: word address width, must match the controller.
- DATA_W, 32: data width; mask width is DATA_W/8.

Ports:
- clk  in  1  single clock, shared with the SDRAM controller.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_PORTS  per-port request; held high until the matching req_ready.
- req_addr  in  NUM_PORTS*ADDR_W  per-port word address, packed with port 0 in the LSBs.
- req_wdata  in  NUM_PORTS*DATA_W  per-port write data.
- req_wmask  in  NUM_PORTS*DATA_W/8  per-port byte mask; all zero means a read.
- req_ready  out  NUM_PORTS  one-cycle completion pulse per port.
- req_rdata  out  DATA_W  read data, valid in the req_ready cycle; shared by all ports.
- mem_valid  out  1  to the controller's valid input.
- mem_addr  out  ADDR_W  to the controller's address input.
- mem_wdata  out  DATA_W  to the controller's write-data input.
- mem_wmask  out  DATA_W/8  to the controller's write-mask input.
- mem_rdata  in  DATA_W  from the controller's read-data output.
- mem_ready  in  1  from the controller; a one-cycle pulse.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any req_valid bit is high, pick grant g round-robin.
  - Search starts at last_grant+1 modulo NUM_PORTS.
  - Latch addr, wdata and wmask of port g into mem_* registers.
  - Record g; set last_grant to g; go to BUSY.
- **BUSY**
  - mem_valid = busy_q & ~mem_ready. This is a combinational gate: the controller samples valid in the same cycle it asserts ready, so valid must be low in that cycle.
  - mem_addr, mem_wdata and mem_wmask stay constant throughout BUSY.
  - On mem_ready: register mem_rdata into req_rdata and go to RESP.
- **RESP**
  - req_ready[g] = 1 for exactly this cycle; all other bits are 0.
  - Go to IDLE.
  - Requests are not evaluated in RESP. The granted port's req_valid is still high from the completed request and must not be re-granted.
- Other ports' req_valid and data may change freely while they are not granted. Only port g's inputs are ignored after capture.
- Reset values:
  - state = IDLE, last_grant = NUM_PORTS-1 (so port 0 wins first).
  - mem_valid = 0, mem_addr / mem_wdata / mem_wmask = 0.
  - req_ready = 0, req_rdata = 0.
- Reset mid-access: the arbiter drops everything. The controller shares the reset net and restarts its own init sequence; no response is delivered.
- mem_ready outside BUSY is ignored. This is a protocol error; flag it with a simulation-only assertion.
- Round-robin means that with all ports requesting continuously, grants cycle 0,1,…,N-1,0.
- No port waits more than NUM_PORTS-1 other accesses.

## Timing
- Request to mem_valid: req_valid high in IDLE at cycle T gives mem_valid high from T+1.
- mem_ready at cycle M gives req_ready[g] and req_rdata at M+1.
- Added overhead is 2 cycles per access: the capture cycle plus the RESP cycle. SDRAM latency itself is set by the controller (ACT, tRCD, CAS, tRP, plus any auto-refresh in progress).
- Minimum port-to-port turnaround: a new grant is made in the IDLE cycle after RESP.
- Simultaneous events:
  - Several req_valid bits rising in the same IDLE cycle: exactly one is granted.
  - mem_ready and a new req_valid in the same cycle: the new request waits until IDLE.

## Structure
- Shared package sdram_arb_pkg holds:
  - the default ADDR_W and DATA_W constants;
  - the state encoding localparams (IDLE=0, BUSY=1, RESP=2);
  - an index-width helper, clog2 of NUM_PORTS.
- Sub-module rr_pick: a combinational round-robin selector. Inputs: request vector, last_grant. Outputs: grant index and any_req.
- The top level holds the FSM, capture registers, muxes and response routing.

## Test plan
- **Single read.** Port 0 reads addr 0x00123 while a controller model returns 0xDEADBEEF 10 cycles later.
  - Expect mem_valid at T+1 with mem_addr=0x00123 and mem_wmask=0.
  - Expect req_ready[0] one cycle after mem_ready, with req_rdata=0xDEADBEEF; req_ready[1] stays 0.
- **Write passthrough.** Port 1 writes 0x11223344 with mask 4'b0101 to 0x1FFFFF.
  - Expect mem_wdata, mem_wmask and mem_addr to match the request and stay stable for every BUSY cycle.
- **Contention.** Both ports hold req_valid continuously for 6 accesses.
  - Expect grant order 0,1,0,1,0,1 and exactly 6 req_ready pulses.
- **No double issue.** In every cycle where mem_ready=1, expect mem_valid=0.
  - The controller model counts accesses and must see exactly one per request, including back-to-back requests from the same port.
- **Reset mid-access.** Assert reset for 1 cycle while in BUSY.
  - Expect mem_valid=0 and req_ready=0 the next cycle, state IDLE, and no req_ready for the aborted request.
  - A following port-0 request then completes normally.
- **Stray ready.** Pulse mem_ready while in IDLE.
  - Expect no req_ready and no state change; the simulation assertion fires.
